onehot_stream_encoder: RTL and testbench

- Encoder counterpart to the team's 2-to-4 line decoder: converts a multi-hot line vector back into binary indices.
- Each accepted vector is serialised into a stream of indices of its set bits, lowest index first, one beat per handshake.
- Sits between request/line producers (interrupt lines, decoded selects) and consumers that need a binary index, with valid/ready flow control on both sides.

---
 rtl/enc_pkg.sv | 16 +
 rtl/lsb_index_encode.sv | 35 +++
 rtl/onehot_stream_encoder.sv | 95 +++++++++
 tb/tb_onehot_stream_encoder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the one-hot / multi-hot stream encoder.
//   enc_state_t : encoder control state (IDLE waits for a vector, EMIT streams beats)
//   clog2_min1  : index width helper, never returns less than 1 so a
//                 two-line encoder still gets a 1-bit index.
package enc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsb_index_encode.sv
// Combinational lowest-set-bit encoder.
// Ports:
//   vec_i    [WIDTH-1:0] : multi-hot input vector
//   idx_o    [IDX_W-1:0] : binary index of the lowest set bit (0 when vec_i is 0)
//   mask_o   [WIDTH-1:0] : one-hot mask of that lowest set bit (0 when vec_i is 0)
//   zero_o               : vec_i has no bits set
//   single_o             : vec_i has exactly one bit set
module lsb_index_encode #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             zero_o,
  output logic             single_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  // Two's-complement trick: v & -v isolates the lowest set bit.
  assign mask_o   = vec_i & (~vec_i + WIDTH'(1));
  assign zero_o   = (vec_i == '0);
  // v & (v-1) clears the lowest set bit; nothing left means only one was set.
  assign single_o = !zero_o && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/onehot_stream_encoder.sv
// Multi-hot line vector to binary index stream.
// Each accepted vector is emitted as one beat per set bit, lowest index
// first; an all-zero vector produces a single beat flagged out_none.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : input handshake for in_vec
//   in_vec [WIDTH-1:0]  : multi-hot line vector
//   out_valid/out_ready : output handshake for the current beat
//   out_idx [IDX_W-1:0] : index of the current set bit
//   out_last            : current beat is the final one for this vector
//   out_none            : accepted vector was all-zero (out_idx is 0)
//   busy                : a vector is held and being emitted
module onehot_stream_encoder
  import enc_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;

  logic [IDX_W-1:0] lsb_idx;
  logic [WIDTH-1:0] lsb_mask;
  logic             lsb_zero;
  logic             lsb_single;
  logic             emit;
  logic             out_fire;
  logic             accept;

  // One encoder serves both the output decode and the clear-lowest-bit step.
  lsb_index_encode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb (
    .vec_i    (residual_q),
    .idx_o    (lsb_idx),
    .mask_o   (lsb_mask),
    .zero_o   (lsb_zero),
    .single_o (lsb_single)
  );

  // Outputs decode only registered state, so there is no input-to-output
  // combinational path; gating with emit keeps them at 0 while idle.
  assign emit      = (state_q == EMIT);
  assign out_valid = emit;
  assign busy      = emit;
  assign out_idx   = emit ? lsb_idx : '0;
  assign out_last  = emit & (lsb_single | lsb_zero);
  assign out_none  = emit & lsb_zero;

  assign out_fire  = out_valid & out_ready;
  // Accept while idle, or on the last-beat handshake for a zero-bubble reload.
  assign in_ready  = ~emit | (out_fire & out_last);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    if (out_fire) begin
      residual_d = residual_q & ~lsb_mask;
      if (out_last) begin
        state_d = IDLE;
      end
    end
    // A new vector overrides the drain of the previous one.
    if (accept) begin
      residual_d = in_vec;
      state_d    = EMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      residual_q <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
    end
  end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
module tb_onehot_stream_encoder;

  typedef struct {
    int idx;
    bit last;
    bit none;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       rst_n4 = 1'b0;
  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_vec4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [1:0] out_idx4;
  logic       out_last4;
  logic       out_none4;
  logic       busy4;

  onehot_stream_encoder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_vec    (in_vec4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_idx   (out_idx4),
    .out_last  (out_last4),
    .out_none  (out_none4),
    .busy      (busy4)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic       rst_n8 = 1'b0;
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] in_vec8 = '0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [2:0] out_idx8;
  logic       out_last8;
  logic       out_none8;
  logic       busy8;
  bit         rand8_en = 1'b0;

  onehot_stream_encoder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_vec    (in_vec8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_idx   (out_idx8),
    .out_last  (out_last8),
    .out_none  (out_none8),
    .busy      (busy8)
  );

  beat_t q4[$];
  beat_t q8[$];
  int    beat_cyc4[$];

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp4(input int idx, input bit last, input bit none);
    beat_t b;
    b.idx = idx; b.last = last; b.none = none;
    q4.push_back(b);
  endtask

  // Reference for WIDTH=8: walk bits upward, last when no set bits remain.
  task automatic model8(input logic [7:0] v);
    beat_t b;
    int rem;
    if (v == 8'h00) begin
      b.idx = 0; b.last = 1'b1; b.none = 1'b1;
      q8.push_back(b);
    end else begin
      rem = $countones(v);
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          rem--;
          b.idx = i; b.last = (rem == 0); b.none = 1'b0;
          q8.push_back(b);
        end
      end
    end
  endtask

  // ---------------- monitors / scoreboards ----------------
  bit       stall4_prev = 1'b0;
  int       hold_idx4;
  bit       hold_last4, hold_none4;

  always @(negedge clk) begin
    beat_t e;
    if (stall4_prev) begin
      chk("hold_valid4", out_valid4, 1);
      chk("hold_idx4", out_idx4, hold_idx4);
      chk("hold_last4", out_last4, hold_last4);
      chk("hold_none4", out_none4, hold_none4);
    end
    if (out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        chk("unexpected_beat4_idx", out_idx4, -1);
      end else begin
        e = q4.pop_front();
        chk("beat4_idx", out_idx4, e.idx);
        chk("beat4_last", out_last4, e.last);
        chk("beat4_none", out_none4, e.none);
        beat_cyc4.push_back(cyc);
      end
    end
    stall4_prev = rst_n4 && out_valid4 && !out_ready4;
    hold_idx4   = out_idx4;
    hold_last4  = out_last4;
    hold_none4  = out_none4;
  end

  bit       stall8_prev = 1'b0;
  int       hold_idx8;
  bit       hold_last8, hold_none8;

  always @(negedge clk) begin
    beat_t e;
    if (stall8_prev) begin
      chk("hold_valid8", out_valid8, 1);
      chk("hold_idx8", out_idx8, hold_idx8);
      chk("hold_last8", out_last8, hold_last8);
      chk("hold_none8", out_none8, hold_none8);
    end
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        chk("unexpected_beat8_idx", out_idx8, -1);
      end else begin
        e = q8.pop_front();
        chk("beat8_idx", out_idx8, e.idx);
        chk("beat8_last", out_last8, e.last);
        chk("beat8_none", out_none8, e.none);
      end
    end
    stall8_prev = rst_n8 && out_valid8 && !out_ready8;
    hold_idx8   = out_idx8;
    hold_last8  = out_last8;
    hold_none8  = out_none8;
  end

  // Random output backpressure for the WIDTH=8 run.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand8_en) out_ready8 = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- drivers ----------------
  task automatic send4(input logic [3:0] v);
    bit done = 1'b0;
    in_valid4 = 1'b1;
    in_vec4   = v;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready4) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid4 = 1'b0;
    if (!done) chk("send4_timeout", 0, 1);
    $display("dut4 vector %b accepted at cycle %0d", v, cyc);
  endtask

  task automatic send8(input logic [7:0] v);
    bit done = 1'b0;
    in_valid8 = 1'b1;
    in_vec8   = v;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready8) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    if (!done) chk("send8_timeout", 0, 1);
    $display("dut8 vector %b accepted at cycle %0d", v, cyc);
  endtask

  // Wait until every expected beat has been seen, then expect idle.
  task automatic drain4();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #2;
      if (q4.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain4_timeout", q4.size(), 0);
    chk("drain4_in_ready", in_ready4, 1);
    chk("drain4_out_valid", out_valid4, 0);
  endtask

  task automatic drain8();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      #2;
      if (q8.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain8_timeout", q8.size(), 0);
    chk("drain8_in_ready", in_ready8, 1);
    chk("drain8_out_valid", out_valid8, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] rv;

    repeat (3) @(posedge clk);
    #1;
    rst_n4 = 1'b1;
    rst_n8 = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid4, 0);
    chk("reset_out_idx", out_idx4, 0);
    chk("reset_out_last", out_last4, 0);
    chk("reset_out_none", out_none4, 0);
    chk("reset_busy", busy4, 0);
    chk("reset_in_ready", in_ready4, 1);
    chk("reset8_out_valid", out_valid8, 0);
    chk("reset8_in_ready", in_ready8, 1);
    @(posedge clk);
    #1;

    // 1010 -> idx 1, idx 3 (last)
    exp4(1, 0, 0);
    exp4(3, 1, 0);
    send4(4'b1010);
    chk("first_beat_busy", busy4, 1);
    drain4();

    // zero vector -> single none beat
    exp4(0, 1, 1);
    send4(4'b0000);
    drain4();

    // 1111 with out_ready toggling 1,0,1,0,...
    exp4(0, 0, 0);
    exp4(1, 0, 0);
    exp4(2, 0, 0);
    exp4(3, 1, 0);
    send4(4'b1111);
    for (int k = 0; k < 8; k++) begin
      out_ready4 = (k % 2 == 0);
      @(negedge clk);
      if (!out_ready4 && out_valid4) chk("stall_in_ready", in_ready4, 0);
      @(posedge clk);
      #1;
    end
    out_ready4 = 1'b1;
    drain4();

    // back-to-back 1000 then 0011 with no bubble
    beat_cyc4.delete();
    exp4(3, 1, 0);
    exp4(0, 0, 0);
    exp4(1, 1, 0);
    send4(4'b1000);
    send4(4'b0011);
    drain4();
    chk("b2b_beats", beat_cyc4.size(), 3);
    if (beat_cyc4.size() == 3) begin
      chk("b2b_gap0", beat_cyc4[1] - beat_cyc4[0], 1);
      chk("b2b_gap1", beat_cyc4[2] - beat_cyc4[1], 1);
    end

    // reset mid-stream on 0110 after the idx=1 beat
    exp4(1, 0, 0);
    exp4(2, 1, 0);
    send4(4'b0110);
    @(posedge clk);
    #1;
    chk("pre_reset_idx", out_idx4, 2);
    rst_n4 = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid4, 0);
    chk("midreset_busy", busy4, 0);
    q4.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n4 = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready4, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_out_valid", out_valid4, 0);

    // WIDTH=8: top bit alone
    q8.push_back('{7, 1'b1, 1'b0});
    send8(8'h80);
    drain8();

    // WIDTH=8 random run with random backpressure
    rand8_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      case (n)
        0:       rv = 8'hFF;
        1:       rv = 8'h00;
        2:       rv = 8'h01;
        default: rv = 8'($urandom_range(0, 255));
      endcase
      model8(rv);
      send8(rv);
    end
    rand8_en = 1'b0;
    out_ready8 = 1'b1;
    drain8();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
